// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg
// Shared definitions for the MIPS pipeline decode stage:
//   - primary opcode constants
//   - bit positions inside the 8-bit ID/EX control word
//     {RegDst, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite}
//   - the control word for each supported instruction class
//   - helpers that classify an opcode and map a class to its control word
package mips_pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int CTRL_REGDST   = 7;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_ALUOP_HI = 4;
    localparam int CTRL_ALUOP_LO = 3;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_ALUSRC   = 1;
    localparam int CTRL_REGWRITE = 0;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_R,
        CLS_LW,
        CLS_SW,
        CLS_ADDI,
        CLS_BEQ,
        CLS_BNE,
        CLS_J
    } instr_class_t;

    // Assembles a control word field by field so the literal tables below
    // stay tied to the bit-index constants.
    function automatic logic [7:0] mk_ctrl(
        input logic       reg_dst,
        input logic       mem_read,
        input logic       mem_to_reg,
        input logic [1:0] alu_op,
        input logic       mem_write,
        input logic       alu_src,
        input logic       reg_write
    );
        logic [7:0] c;
        c = '0;
        c[CTRL_REGDST]                  = reg_dst;
        c[CTRL_MEMREAD]                 = mem_read;
        c[CTRL_MEMTOREG]                = mem_to_reg;
        c[CTRL_ALUOP_HI:CTRL_ALUOP_LO]  = alu_op;
        c[CTRL_MEMWRITE]                = mem_write;
        c[CTRL_ALUSRC]                  = alu_src;
        c[CTRL_REGWRITE]                = reg_write;
        return c;
    endfunction

    localparam logic [7:0] CTRL_R    = mk_ctrl(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1);
    localparam logic [7:0] CTRL_LW   = mk_ctrl(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1);
    localparam logic [7:0] CTRL_SW   = mk_ctrl(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    localparam logic [7:0] CTRL_ADDI = mk_ctrl(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    localparam logic [7:0] CTRL_BR   = mk_ctrl(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    localparam logic [7:0] CTRL_NOP  = 8'h00;

    function automatic instr_class_t classify(input logic [5:0] opcode);
        instr_class_t cls;
        case (opcode)
            OP_RTYPE: cls = CLS_R;
            OP_LW:    cls = CLS_LW;
            OP_SW:    cls = CLS_SW;
            OP_ADDI:  cls = CLS_ADDI;
            OP_BEQ:   cls = CLS_BEQ;
            OP_BNE:   cls = CLS_BNE;
            OP_J:     cls = CLS_J;
            default:  cls = CLS_NOP;
        endcase
        return cls;
    endfunction

    function automatic logic [7:0] ctrl_of(input instr_class_t cls);
        logic [7:0] c;
        case (cls)
            CLS_R:    c = CTRL_R;
            CLS_LW:   c = CTRL_LW;
            CLS_SW:   c = CTRL_SW;
            CLS_ADDI: c = CTRL_ADDI;
            CLS_BEQ:  c = CTRL_BR;
            CLS_BNE:  c = CTRL_BR;
            CLS_J:    c = CTRL_NOP;
            default:  c = CTRL_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// id_regfile
// Architectural register file for the decode stage.
//   clk, rst          : clock, asynchronous active-high reset (clears all entries)
//   we, waddr, wdata  : single write port (writes to register 0 are dropped)
//   raddr_a / rdata_a : read port A
//   raddr_b / rdata_b : read port B
// Reads are combinational and write-through: a write presented in the same
// cycle is returned on a matching read port before it is committed.
module id_regfile #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr_a,
    output logic [XLEN-1:0] rdata_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_b
);

    logic [XLEN-1:0] mem [NREGS];
    logic [AW-1:0]   raddr [2];
    logic [XLEN-1:0] rdata [2];

    // Entry 0 is reset to zero and never written, so it reads as zero too;
    // the explicit check on the read side keeps the write-through path from
    // leaking a write aimed at register 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign raddr[0] = raddr_a;
    assign raddr[1] = raddr_b;
    assign rdata_a  = rdata[0];
    assign rdata_b  = rdata[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                rdata[gi] = mem[raddr[gi]];
                if (raddr[gi] == '0) begin
                    rdata[gi] = '0;
                end else if (we && (waddr == raddr[gi])) begin
                    rdata[gi] = wdata;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/id_stage_hazard_pipe.sv
// id_stage_hazard_pipe
// Decode stage of the 5-stage MIPS pipeline: register file read with
// EX/MEM and WB forwarding, control decode, load-use / branch hazard stall,
// branch and jump resolution, and the ID/EX pipeline register with
// ready/valid backpressure from EX.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   if_valid, if_instr, if_pc: instruction from IF/ID (if_pc is PC+4)
//   id_ready                 : ID consumes the instruction this cycle
//   ex_ready                 : EX accepts the ID/EX contents this cycle
//   idex_*                   : ID/EX register (valid, ctrl, operands, imm, fields)
//   exm_we/addr/data         : EX/MEM result for forwarding
//   wb_we/addr/data          : writeback port (also forwarded)
//   br_taken, br_target      : redirect request to IF
//   stall_cycles             : hazard stall cycle count (only with ID_STALL_CNT_EN)
//
// Build option: define ID_STALL_CNT_EN to add the saturating stall_cycles
// counter output.
module id_stage_hazard_pipe
    import mips_pipe_pkg::*;
#(
    parameter  int XLEN     = 32,
    parameter  int NREGS    = 32,
    parameter  int LOAD_LAT = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            ex_ready,
    output logic            idex_valid,
    output logic [7:0]      idex_ctrl,
    output logic [XLEN-1:0] idex_rs_data,
    output logic [XLEN-1:0] idex_rt_data,
    output logic [XLEN-1:0] idex_imm,
    output logic [AW-1:0]   idex_rs,
    output logic [AW-1:0]   idex_rt,
    output logic [AW-1:0]   idex_rd,
    input  logic            exm_we,
    input  logic [AW-1:0]   exm_addr,
    input  logic [XLEN-1:0] exm_data,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
`ifdef ID_STALL_CNT_EN
    output logic [31:0]     stall_cycles,
`endif
    output logic            br_taken,
    output logic [XLEN-1:0] br_target
);

    // Wide enough for LOAD_LAT+1 with LOAD_LAT up to 7.
    localparam int CNT_W = 4;

    // ---------------- decode ----------------
    logic [5:0]      opcode;
    logic [4:0]      rs_field, rt_field, rd_field;
    logic [AW-1:0]   rs, rt, rd;
    instr_class_t    cls;
    logic [7:0]      dec_ctrl;
    logic            uses_rt;
    logic            is_cond_br;
    logic [XLEN-1:0] imm_sext;

    assign opcode   = if_instr[31:26];
    assign rs_field = if_instr[25:21];
    assign rt_field = if_instr[20:16];
    assign rd_field = if_instr[15:11];
    assign rs       = rs_field[AW-1:0];
    assign rt       = rt_field[AW-1:0];
    assign rd       = rd_field[AW-1:0];
    assign cls      = classify(opcode);
    assign dec_ctrl = ctrl_of(cls);
    assign imm_sext = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};

    // rt is a true source only for instructions that read it; for lw/addi it
    // is the destination and must not trigger a load-use stall.
    assign uses_rt    = (cls == CLS_R) || (cls == CLS_SW) ||
                        (cls == CLS_BEQ) || (cls == CLS_BNE);
    assign is_cond_br = (cls == CLS_BEQ) || (cls == CLS_BNE);

    // ---------------- register file + forwarding ----------------
    logic [XLEN-1:0] rf_a, rf_b;
    logic [AW-1:0]   src_addr [2];
    logic [XLEN-1:0] rf_data  [2];
    logic [XLEN-1:0] fwd_data [2];

    id_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (rs),
        .rdata_a (rf_a),
        .raddr_b (rt),
        .rdata_b (rf_b)
    );

    assign src_addr[0] = rs;
    assign src_addr[1] = rt;
    assign rf_data[0]  = rf_a;
    assign rf_data[1]  = rf_b;

    // EX/MEM is the younger producer, so it takes priority over WB.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                fwd_data[gi] = rf_data[gi];
                if (src_addr[gi] != '0) begin
                    if (exm_we && (exm_addr == src_addr[gi])) begin
                        fwd_data[gi] = exm_data;
                    end else if (wb_we && (wb_addr == src_addr[gi])) begin
                        fwd_data[gi] = wb_data;
                    end
                end
            end
        end
    endgenerate

    // ---------------- hazard detection ----------------
    logic [AW-1:0]    idex_dest;
    logic             idex_is_load;
    logic             idex_is_alu_wr;
    logic             load_hit;
    logic             alu_hit;
    logic [CNT_W-1:0] haz_len;
    logic             hazard_new;
    logic             stall;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    assign idex_dest      = idex_ctrl[CTRL_REGDST] ? idex_rd : idex_rt;
    assign idex_is_load   = idex_valid && idex_ctrl[CTRL_MEMREAD];
    assign idex_is_alu_wr = idex_valid && idex_ctrl[CTRL_REGWRITE] && !idex_ctrl[CTRL_MEMREAD];

    assign load_hit = idex_is_load && (idex_rt != '0) &&
                      ((idex_rt == rs) || (uses_rt && (idex_rt == rt)));
    assign alu_hit  = idex_is_alu_wr && (idex_dest != '0) &&
                      ((idex_dest == rs) || (idex_dest == rt));

    // Number of stall cycles the current instruction needs, 0 if none.
    // A branch compares in ID, so it waits one cycle longer on a load than an
    // ALU consumer does, and must also wait out an ALU producer in ID/EX.
    always_comb begin
        haz_len = '0;
        if (if_valid) begin
            if (is_cond_br && load_hit) begin
                haz_len = CNT_W'(LOAD_LAT + 1);
            end else if (is_cond_br && alu_hit) begin
                haz_len = CNT_W'(1);
            end else if (load_hit) begin
                haz_len = CNT_W'(LOAD_LAT);
            end
        end
    end

    assign hazard_new = (haz_len != '0);
    assign stall      = (cnt_reg != '0) || hazard_new;
    assign id_ready   = ex_ready && !stall;

    // The counter holds the stall cycles still owed including the current
    // one; the detecting cycle already inserts the first bubble, so the load
    // value is decremented immediately if EX accepts it.
    always_comb begin
        cnt_next = '0;
        if (cnt_reg != '0) begin
            cnt_next = ex_ready ? (cnt_reg - CNT_W'(1)) : cnt_reg;
        end else if (hazard_new) begin
            cnt_next = ex_ready ? (haz_len - CNT_W'(1)) : haz_len;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // ---------------- branch resolution ----------------
    logic operands_eq;
    logic br_fire;

    assign operands_eq = (fwd_data[0] == fwd_data[1]);
    assign br_fire     = id_ready && if_valid && !rst;

    always_comb begin
        br_taken = 1'b0;
        if (br_fire) begin
            case (cls)
                CLS_BEQ: br_taken = operands_eq;
                CLS_BNE: br_taken = !operands_eq;
                CLS_J:   br_taken = 1'b1;
                default: br_taken = 1'b0;
            endcase
        end
    end

    assign br_target = (cls == CLS_J) ? {if_pc[XLEN-1:28], if_instr[25:0], 2'b00}
                                      : (if_pc + (imm_sext << 2));

    // ---------------- ID/EX register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_valid   <= 1'b0;
            idex_ctrl    <= '0;
            idex_rs_data <= '0;
            idex_rt_data <= '0;
            idex_imm     <= '0;
            idex_rs      <= '0;
            idex_rt      <= '0;
            idex_rd      <= '0;
        end else if (ex_ready) begin
            if (stall || !if_valid) begin
                idex_valid   <= 1'b0;
                idex_ctrl    <= '0;
                idex_rs_data <= '0;
                idex_rt_data <= '0;
                idex_imm     <= '0;
                idex_rs      <= '0;
                idex_rt      <= '0;
                idex_rd      <= '0;
            end else begin
                idex_valid   <= 1'b1;
                idex_ctrl    <= dec_ctrl;
                idex_rs_data <= fwd_data[0];
                idex_rt_data <= fwd_data[1];
                idex_imm     <= imm_sext;
                idex_rs      <= rs;
                idex_rt      <= rt;
                idex_rd      <= rd;
            end
        end
    end

    // ---------------- optional stall statistics ----------------
`ifdef ID_STALL_CNT_EN
    // Counts cycles lost to hazards only; pure EX backpressure is not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
    // No stall statistics in this build.
`endif

endmodule

// File: tb/tb_id_stage_hazard_pipe.sv
// tb_id_stage_hazard_pipe
// Directed bench for id_stage_hazard_pipe built with LOAD_LAT=2. Inputs are
// driven 1 time unit after the rising edge; combinational outputs are
// sampled 1 unit later and registered outputs 1 unit after the next edge.
module tb_id_stage_hazard_pipe;

    localparam int XLEN     = 32;
    localparam int NREGS    = 32;
    localparam int LOAD_LAT = 2;
    localparam int AW       = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            id_ready;
    logic            ex_ready;
    logic            idex_valid;
    logic [7:0]      idex_ctrl;
    logic [XLEN-1:0] idex_rs_data, idex_rt_data, idex_imm;
    logic [AW-1:0]   idex_rs, idex_rt, idex_rd;
    logic            exm_we;
    logic [AW-1:0]   exm_addr;
    logic [XLEN-1:0] exm_data;
    logic            wb_we;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
`ifdef ID_STALL_CNT_EN
    logic [31:0]     stall_cycles;
`endif

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    id_stage_hazard_pipe #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .LOAD_LAT (LOAD_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .id_ready     (id_ready),
        .ex_ready     (ex_ready),
        .idex_valid   (idex_valid),
        .idex_ctrl    (idex_ctrl),
        .idex_rs_data (idex_rs_data),
        .idex_rt_data (idex_rt_data),
        .idex_imm     (idex_imm),
        .idex_rs      (idex_rs),
        .idex_rt      (idex_rt),
        .idex_rd      (idex_rd),
        .exm_we       (exm_we),
        .exm_addr     (exm_addr),
        .exm_data     (exm_data),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
`ifdef ID_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .br_taken     (br_taken),
        .br_target    (br_target)
    );

    // Expected control words, written out from the decode table.
    localparam logic [7:0] E_R   = 8'b1001_0001;  // 0x91
    localparam logic [7:0] E_LW  = 8'b0110_0011;  // 0x63
    localparam logic [7:0] E_ADD = 8'b0000_0011;  // addi, 0x03
    localparam logic [7:0] E_BR  = 8'b0000_1000;  // 0x08

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] target);
        return {6'h02, target};
    endfunction

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        total++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
        $display("check %-22s observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
    endtask

    initial begin
        rst      = 1'b1;
        if_valid = 1'b0;
        if_instr = '0;
        if_pc    = '0;
        ex_ready = 1'b1;
        exm_we   = 1'b0;
        exm_addr = '0;
        exm_data = '0;
        wb_we    = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;

        // ---- reset state ----
        step();
        step();
        check("rst_idex_valid", idex_valid, 0);
        check("rst_idex_ctrl", idex_ctrl, 0);
        check("rst_idex_rs_data", idex_rs_data, 0);
        check("rst_br_taken", br_taken, 0);
        rst = 1'b0;

        // ---- 1: WB writes r5, then add r1,r5,r0 ----
        wb_we = 1'b1; wb_addr = 5; wb_data = 32'h1234;
        step();
        wb_we = 1'b0;
        issue(enc_r(5, 0, 1), 32'h0000_0010);
        #1;
        check("t1_id_ready", id_ready, 1);
        step();
        check("t1_idex_valid", idex_valid, 1);
        check("t1_idex_ctrl", idex_ctrl, E_R);
        check("t1_rs_data", idex_rs_data, 32'h1234);
        check("t1_rt_data", idex_rt_data, 0);
        check("t1_idex_rd", idex_rd, 1);

        // ---- 2: lw r2,0(r1) then add r3,r2,r2 (two bubbles) ----
        issue(enc_i(6'h23, 1, 2, 16'h0000), 32'h0000_0014);
        step();
        check("t2_lw_ctrl", idex_ctrl, E_LW);
        check("t2_lw_rt", idex_rt, 2);
        issue(enc_r(2, 2, 3), 32'h0000_0018);
        #1;
        check("t2_stall0_ready", id_ready, 0);
        step();
        check("t2_bubble1_valid", idex_valid, 0);
        check("t2_bubble1_ctrl", idex_ctrl, 0);
        check("t2_stall1_ready", id_ready, 0);
        step();
        check("t2_bubble2_valid", idex_valid, 0);
        wb_we = 1'b1; wb_addr = 2; wb_data = 32'hDEAD_BEEF;
        #1;
        check("t2_release_ready", id_ready, 1);
        step();
        wb_we = 1'b0;
        check("t2_add_valid", idex_valid, 1);
        check("t2_add_rs_data", idex_rs_data, 32'hDEAD_BEEF);
        check("t2_add_rt_data", idex_rt_data, 32'hDEAD_BEEF);
        check("t2_add_rd", idex_rd, 3);

        // ---- 3: EX/MEM beats WB; WB commit; r0 never forwarded ----
        exm_we = 1'b1; exm_addr = 4; exm_data = 32'hAA;
        wb_we  = 1'b1; wb_addr  = 4; wb_data  = 32'hBB;
        issue(enc_r(4, 0, 7), 32'h0000_001C);
        step();
        check("t3_exm_priority", idex_rs_data, 32'hAA);
        exm_we = 1'b0; wb_we = 1'b0;
        issue(enc_r(4, 4, 8), 32'h0000_0020);
        step();
        check("t3_rf_rs_r4", idex_rs_data, 32'hBB);
        check("t3_rf_rt_r4", idex_rt_data, 32'hBB);
        exm_we = 1'b1; exm_addr = 0; exm_data = 32'h55;
        wb_we  = 1'b1; wb_addr  = 0; wb_data  = 32'h66;
        issue(enc_r(0, 0, 9), 32'h0000_0024);
        #1;
        check("t3_r0_ready", id_ready, 1);
        step();
        check("t3_r0_rs_data", idex_rs_data, 0);
        check("t3_r0_rt_data", idex_rt_data, 0);
        exm_we = 1'b0; wb_we = 1'b0;

        // ---- 4: beq/bne, branch behind an ALU producer ----
        issue(enc_i(6'h04, 1, 1, 16'd3), 32'h0000_0100);
        #1;
        check("t4_beq_taken", br_taken, 1);
        check("t4_beq_target", br_target, 32'h0000_010C);
        step();
        check("t4_beq_ctrl", idex_ctrl, E_BR);
        check("t4_beq_valid", idex_valid, 1);
        issue(enc_i(6'h05, 1, 1, 16'd3), 32'h0000_0104);
        #1;
        check("t4_bne_not_taken", br_taken, 0);
        step();
        issue(enc_i(6'h08, 0, 10, 16'd5), 32'h0000_0108);
        step();
        check("t4_addi_ctrl", idex_ctrl, E_ADD);
        check("t4_addi_imm", idex_imm, 5);
        issue(enc_i(6'h05, 10, 0, 16'd1), 32'h0000_0200);
        #1;
        check("t4_brhaz_ready", id_ready, 0);
        check("t4_brhaz_no_taken", br_taken, 0);
        step();
        check("t4_brhaz_bubble", idex_valid, 0);
        exm_we = 1'b1; exm_addr = 10; exm_data = 32'd5;
        #1;
        check("t4_br_fwd_ready", id_ready, 1);
        check("t4_br_fwd_taken", br_taken, 1);
        check("t4_br_fwd_target", br_target, 32'h0000_0204);
        step();
        exm_we = 1'b0;

        // ---- 5: backpressure during a load-use stall ----
        issue(enc_i(6'h23, 0, 11, 16'h0000), 32'h0000_0300);
        step();
        issue(enc_r(11, 0, 12), 32'h0000_0304);
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("t5_hold%0d_ready", i), id_ready, 0);
            step();
            check($sformatf("t5_hold%0d_ctrl", i), idex_ctrl, E_LW);
            check($sformatf("t5_hold%0d_valid", i), idex_valid, 1);
        end
        ex_ready = 1'b1;
        #1;
        check("t5_rel0_ready", id_ready, 0);
        step();
        check("t5_rel1_valid", idex_valid, 0);
        check("t5_rel1_ready", id_ready, 0);
        step();
        check("t5_rel2_valid", idex_valid, 0);
        wb_we = 1'b1; wb_addr = 11; wb_data = 32'h77;
        #1;
        check("t5_rel2_ready", id_ready, 1);
        step();
        wb_we = 1'b0;
        check("t5_add_rs_data", idex_rs_data, 32'h77);
        check("t5_add_rd", idex_rd, 12);

        // ---- 6: jump, then reset mid-stall ----
        issue(enc_j(26'h000_0040), 32'h4000_0008);
        #1;
        check("t6_j_taken", br_taken, 1);
        check("t6_j_target", br_target, 32'h4000_0100);
        step();
        check("t6_j_ctrl", idex_ctrl, 0);
        check("t6_j_valid", idex_valid, 1);
        issue(enc_i(6'h23, 0, 13, 16'h0000), 32'h4000_000C);
        step();
        issue(enc_r(13, 0, 14), 32'h4000_0010);
        step();
        check("t6_midstall_ready", id_ready, 0);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", idex_valid, 0);
        check("t6_rst_ready", id_ready, 1);
        ex_ready = 1'b0;
        #1;
        check("t6_rst_ready_bp", id_ready, 0);
        ex_ready = 1'b1;
        rst = 1'b0;
        #1;
        check("t6_post_rst_ready", id_ready, 1);
        step();
        check("t6_post_rst_valid", idex_valid, 1);
        check("t6_post_rst_ctrl", idex_ctrl, E_R);
        issue(enc_r(5, 0, 15), 32'h4000_0014);
        step();
        check("t6_rf_cleared_r5", idex_rs_data, 0);
        if_valid = 1'b0;
        step();
        check("t6_idle_bubble", idex_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
